// File: rtl/if_fetch_if.sv
// Instruction-bus interface between the fetch stage and instruction memory.
// master drives req/addr, slave returns ack/rdata.
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ibus_req_o;
    logic [ADDR_W-1:0] ibus_addr_o;
    logic              ibus_ack_i;
    logic [DATA_W-1:0] ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_ack_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_ack_i,
        output ibus_rdata_i
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, single-outstanding req/ack fetch.
// Ports: clk, rst (async low), stall/redirect from decode, ibus, pc/inst out.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    if_fetch_if.master        ibus,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        RESET_WAIT,
        FETCH,
        SKID,
        DROP
    } state_t;

    localparam logic [ADDR_W-1:0] PC0 = RESET_PC[ADDR_W-1:0];

    state_t            state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;

    logic              ack;
    logic              out_free;
    logic [ADDR_W-1:0] tgt_in;
    logic [ADDR_W-1:0] addr_nxt;

    assign ack      = req_q & ibus.ibus_ack_i;
    assign out_free = ~inst_valid_o | ~stall_i;
    assign tgt_in   = redirect_pc_i & ~ADDR_W'(3);
    assign addr_nxt = addr_q + ADDR_W'(4);

    assign ibus.ibus_req_o  = req_q;
    assign ibus.ibus_addr_o = addr_q;

    // The skid register is only ever full in SKID, so the state doubles
    // as its occupancy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RESET_WAIT;
            req_q        <= 1'b0;
            addr_q       <= PC0;
            tgt_q        <= '0;
            skid_pc      <= '0;
            skid_inst    <= '0;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            unique case (state)
                RESET_WAIT: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    if (redirect_i) begin
                        addr_q       <= tgt_in;
                        inst_valid_o <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect_i) begin
                        inst_valid_o <= 1'b0;
                        if (ack) begin
                            addr_q <= tgt_in;
                        end else begin
                            // Request in flight: address must hold
                            // until its ack, which is then discarded.
                            tgt_q <= tgt_in;
                            state <= DROP;
                        end
                    end else if (ack) begin
                        addr_q <= addr_nxt;
                        if (out_free) begin
                            pc_o         <= addr_q;
                            inst_o       <= ibus.ibus_rdata_i;
                            inst_valid_o <= 1'b1;
                        end else begin
                            skid_pc   <= addr_q;
                            skid_inst <= ibus.ibus_rdata_i;
                            req_q     <= 1'b0;
                            state     <= SKID;
                        end
                    end else if (!stall_i) begin
                        inst_valid_o <= 1'b0;
                    end
                end
                SKID: begin
                    if (redirect_i) begin
                        inst_valid_o <= 1'b0;
                        addr_q       <= tgt_in;
                        req_q        <= 1'b1;
                        state        <= FETCH;
                    end else if (!stall_i) begin
                        pc_o         <= skid_pc;
                        inst_o       <= skid_inst;
                        inst_valid_o <= 1'b1;
                        req_q        <= 1'b1;
                        state        <= FETCH;
                    end
                end
                DROP: begin
                    inst_valid_o <= 1'b0;
                    if (ack) begin
                        addr_q <= redirect_i ? tgt_in : tgt_q;
                        state  <= FETCH;
                    end else if (redirect_i) begin
                        tgt_q <= tgt_in;
                    end
                end
                default: begin
                    state <= RESET_WAIT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch; memory returns addr ^ 32'hDEAD0000.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_fetch #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .ibus         (bus.master),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    assign bus.ibus_rdata_i = bus.ibus_addr_o ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ibus_ack_i = 1'b0;
        #2;
        chk("rst_req",   {31'b0, bus.ibus_req_o}, 32'd0);
        chk("rst_addr",  bus.ibus_addr_o, 32'h0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_pc",    pc_o, 32'h0);
        chk("rst_inst",  inst_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        step(); // edge 1
        chk("c1_req",   {31'b0, bus.ibus_req_o}, 32'd1);
        chk("c1_addr",  bus.ibus_addr_o, 32'h0);
        chk("c1_valid", {31'b0, inst_valid_o}, 32'd0);
        bus.ibus_ack_i = 1'b1;

        step(); // edge 2
        chk("c2_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("c2_pc",    pc_o, 32'h0);
        chk("c2_inst",  inst_o, 32'hDEAD_0000);
        chk("c2_addr",  bus.ibus_addr_o, 32'h4);
        step(); // edge 3
        chk("c3_pc",    pc_o, 32'h4);
        chk("c3_addr",  bus.ibus_addr_o, 32'h8);
        step(); // edge 4
        chk("c4_pc",    pc_o, 32'h8);
        chk("c4_inst",  inst_o, 32'hDEAD_0008);
        chk("c4_addr",  bus.ibus_addr_o, 32'hC);

        stall_i = 1'b1;
        step(); // ack for 0xC goes to skid
        chk("sk_pc",    pc_o, 32'h8);
        chk("sk_req",   {31'b0, bus.ibus_req_o}, 32'd0);
        chk("sk_addr",  bus.ibus_addr_o, 32'h10);
        step();
        step();
        chk("sk_hold",  pc_o, 32'h8);
        chk("sk_req2",  {31'b0, bus.ibus_req_o}, 32'd0);
        stall_i = 1'b0;
        step();
        chk("sk_out_pc",   pc_o, 32'hC);
        chk("sk_out_inst", inst_o, 32'hDEAD_000C);
        chk("sk_out_v",    {31'b0, inst_valid_o}, 32'd1);
        chk("sk_out_req",  {31'b0, bus.ibus_req_o}, 32'd1);
        chk("sk_out_addr", bus.ibus_addr_o, 32'h10);
        step();
        chk("sk_next_pc",  pc_o, 32'h10);

        // redirect to 0x20 with ack: acked 0x14 word discarded
        redirect_i = 1'b1;
        redirect_pc_i = 32'h20;
        step();
        chk("rd_addr",  bus.ibus_addr_o, 32'h20);
        chk("rd_valid", {31'b0, inst_valid_o}, 32'd0);
        bus.ibus_ack_i = 1'b0;
        redirect_pc_i = 32'h100;
        step();
        chk("dr_addr1", bus.ibus_addr_o, 32'h20);
        chk("dr_req1",  {31'b0, bus.ibus_req_o}, 32'd1);
        redirect_pc_i = 32'h200;
        step();
        chk("dr_addr2", bus.ibus_addr_o, 32'h20);
        redirect_i = 1'b0;
        step();
        chk("dr_hold",  bus.ibus_addr_o, 32'h20);
        chk("dr_valid", {31'b0, inst_valid_o}, 32'd0);
        bus.ibus_ack_i = 1'b1;
        step();
        chk("dr_new_addr", bus.ibus_addr_o, 32'h200);
        chk("dr_drop_v",   {31'b0, inst_valid_o}, 32'd0);
        step();
        chk("dr_pc",    pc_o, 32'h200);
        chk("dr_inst",  inst_o, 32'hDEAD_0200);
        chk("dr_v",     {31'b0, inst_valid_o}, 32'd1);

        // 0x40 valid and stalled; redirect 0x80 while 0x44 acks
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        step();
        chk("rs_pc40",  pc_o, 32'h40);
        chk("rs_addr",  bus.ibus_addr_o, 32'h44);
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        step();
        chk("rs_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rs_addr2", bus.ibus_addr_o, 32'h80);
        chk("rs_req",   {31'b0, bus.ibus_req_o}, 32'd1);
        stall_i = 1'b0;
        redirect_i = 1'b0;
        step();
        chk("rs_pc80",  pc_o, 32'h80);
        chk("rs_inst",  inst_o, 32'hDEAD_0080);

        // unaligned target near top of address space
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        step();
        chk("wr_addr",  bus.ibus_addr_o, 32'hFFFF_FFFC);
        redirect_i = 1'b0;
        step();
        chk("wr_pc",    pc_o, 32'hFFFF_FFFC);
        chk("wr_inst",  inst_o, 32'h2152_FFFC);
        chk("wr_wrap",  bus.ibus_addr_o, 32'h0);

        // enter SKID, then async reset between edges
        stall_i = 1'b1;
        step();
        chk("ar_skid_req", {31'b0, bus.ibus_req_o}, 32'd0);
        chk("ar_skid_pc",  pc_o, 32'hFFFF_FFFC);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req",   {31'b0, bus.ibus_req_o}, 32'd0);
        chk("ar_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("ar_pc",    pc_o, 32'h0);
        chk("ar_inst",  inst_o, 32'h0);
        chk("ar_addr",  bus.ibus_addr_o, 32'h0);
        stall_i = 1'b0;
        bus.ibus_ack_i = 1'b0;
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("ar_r_req",  {31'b0, bus.ibus_req_o}, 32'd1);
        chk("ar_r_addr", bus.ibus_addr_o, 32'h0);
        bus.ibus_ack_i = 1'b1;
        step();
        chk("ar_r_pc",   pc_o, 32'h0);
        chk("ar_r_inst", inst_o, 32'hDEAD_0000);
        chk("ar_r_v",    {31'b0, inst_valid_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues single-outstanding requests on a req/ack instruction bus.
- Presents pc_o/inst_o/inst_valid_o to decode. Holds them under stall, buffering one returned word in a skid register.
- Handles redirects (branch/jump targets), including discarding a fetch already in flight.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- ADDR_W, 32, PC / bus address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode did not consume the current output; hold pc_o/inst_o.
- redirect_i  in  1  one-cycle pulse; change fetch stream to redirect_pc_i.
- redirect_pc_i  in  ADDR_W  redirect target; bits[1:0] forced to 00.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  ADDR_W  fetch address; stable while req high and not acked.
- ibus_ack_i  in  1  response valid; ignored when ibus_req_o=0.
- ibus_rdata_i  in  DATA_W  instruction word, valid with ack.
- pc_o  out  ADDR_W  PC of inst_o.
- inst_o  out  DATA_W  instruction to decode.
- inst_valid_o  out  1  pc_o/inst_o are a live instruction.

Behaviour:
- Reset (rst=0, async): state=RESET_WAIT, ibus_req_o=0, ibus_addr_o=RESET_PC, pc_o=0, inst_o=0 (decodes as NOP), inst_valid_o=0, skid empty, redirect target cleared. A reset mid-request abandons it; the bus must tolerate this.
- States: RESET_WAIT, FETCH, SKID, DROP.
- ibus_req_o=1 in FETCH and DROP, 0 otherwise.
- Handshake: ack counts only when sampled with req=1. ack may arrive in the same cycle as req, giving 1 instr/clk sustained. ibus_addr_o never changes while req=1 and no ack.
- RESET_WAIT: first edge after reset release goes to FETCH with addr=RESET_PC. The first request is visible in cycle 1.
- Consumption: "output free" = inst_valid_o=0 OR stall_i=0.
- FETCH, ack, output free, no redirect:
  - pc_o<=ibus_addr_o, inst_o<=ibus_rdata_i, inst_valid_o<=1.
  - ibus_addr_o<=ibus_addr_o+4, modulo 2^ADDR_W (32'hFFFFFFFC wraps to 0).
  - Stay in FETCH.
- FETCH, ack, output not free: capture {addr, rdata} into skid; addr<=addr+4; go to SKID. Outputs held.
- FETCH, no ack: if stall_i=0, inst_valid_o<=0 (bubble); otherwise hold.
- SKID (req=0): when stall_i=0, outputs<=skid, inst_valid_o<=1, skid emptied, go to FETCH. While stall_i=1, hold everything.
- Redirect has priority over stall and ack. At the edge where redirect_i=1, inst_valid_o<=0 and the skid is emptied. Then, by state:
  - RESET_WAIT or SKID: addr<=target, go to FETCH.
  - FETCH with ack: acked word discarded, addr<=target, stay in FETCH.
  - FETCH without ack: latch target, go to DROP. Addr held, req stays 1.
  - DROP without ack: a new redirect overwrites the latched target.
- DROP, ack: word discarded, addr<=latched target, go to FETCH.
- DROP, no ack: hold. inst_valid_o stays 0.
- Words fetched before a redirect never reach inst_o after the redirect edge.
- No state accepts more than one outstanding request. The skid holds at most one entry, and req=0 while it is full, so it cannot overflow.

Test Plan:
- Reset then ack tied high, stall=0: req=1 from cycle 1. Addrs 0,4,8,... back-to-back. inst_valid_o=1 from cycle 2, pc_o follows one cycle behind addr, rdata appears on inst_o unchanged.
- Stall with ack: valid output pc=8; stall_i=1 for 3 cycles while ack returns word for addr 12. Then:
  - pc_o stays 8; req drops after the ack.
  - On release, pc_o=12 with the correct inst_o, and req reasserts with addr=16.
- Redirect during outstanding request: addr=0x20 req=1, no ack; redirect_i with 0x100 (then 0x200 the next cycle, still no ack).
  - addr stays 0x20 until ack; that word is not presented.
  - Next req addr=0x200; inst_valid_o=0 until the 0x200 word returns.
- Redirect same cycle as ack and stall: 0x40 is valid and stalled; redirect to 0x80 while the ack for 0x44 arrives.
  - 0x44 is dropped, the skid stays empty, inst_valid_o=0.
  - Next addr=0x80.
- Wrap and alignment: redirect to 0xFFFFFFFE gives addr 0xFFFFFFFC; next addr=0x00000000.
- Async reset mid-SKID: assert rst low between edges. Outputs immediately 0 (req=0, inst_valid_o=0). After release the fetch restarts at RESET_PC.
